// File: rtl/lcd_hd44780_hex.sv
// HD44780 8-bit-mode writer: power-up wait, init command list, then continuous
// refresh of a and b as 16 uppercase hex digits on lines 1 and 2.
module lcd_hd44780_hex #(
   parameter int T_PWRUP_CYC = 1_000_000,
   parameter int T_E_CYC     = 25,
   parameter int T_CMD_CYC   = 2_500,
   parameter int T_CLR_CYC   = 100_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic        lcd_rs,
   output logic        lcd_e,
   output logic [7:0]  lcd_d,
   output logic        init_done,
   output logic        frame_done
);
   localparam int M1    = (T_PWRUP_CYC > T_E_CYC) ? T_PWRUP_CYC : T_E_CYC;
   localparam int M2    = (T_CMD_CYC > T_CLR_CYC) ? T_CMD_CYC : T_CLR_CYC;
   localparam int T_MAX = (M1 > M2) ? M1 : M2;
   localparam int TW    = $clog2(T_MAX) + 1;

   typedef enum logic [2:0] {S_PWRUP, S_INIT, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2, S_FRAME} state_t;
   typedef enum logic [1:0] {P_SETUP, P_PULSE, P_WAIT} phase_t;

   state_t          state_q, state_d;
   phase_t          phase_q, phase_d;
   logic [TW-1:0]   tmr_q, tmr_d, wait_len;
   logic [3:0]      idx_q, idx_d;
   logic            e_q, e_d, rs_q, rs_d, init_q, init_d, fdone_q, fdone_d, start;
   logic [7:0]      dat_q, dat_d;
   logic [63:0]     snap_a_q, snap_a_d, snap_b_q, snap_b_d;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
   endfunction

   // {rs, byte} of the transfer identified by state and index; index 0 is the top nibble
   function automatic logic [8:0] byte_for(input state_t s, input logic [3:0] i,
                                           input logic [63:0] sa, input logic [63:0] sb);
      logic [5:0] lsb;
      lsb = {~i, 2'b00};
      case (s)
         S_INIT: begin
            case (i)
               4'd0, 4'd1, 4'd2: return {1'b0, 8'h38};
               4'd3:             return {1'b0, 8'h0C};
               4'd4:             return {1'b0, 8'h06};
               default:          return {1'b0, 8'h01};
            endcase
         end
         S_ADDR1: return {1'b0, 8'h80};
         S_LINE1: return {1'b1, hex_char(sa[lsb +: 4])};
         S_ADDR2: return {1'b0, 8'hC0};
         S_LINE2: return {1'b1, hex_char(sb[lsb +: 4])};
         default: return 9'h000;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      tmr_d    = tmr_q + TW'(1);
      idx_d    = idx_q;
      e_d      = e_q;
      rs_d     = rs_q;
      dat_d    = dat_q;
      init_d   = init_q;
      fdone_d  = 1'b0;
      snap_a_d = snap_a_q;
      snap_b_d = snap_b_q;
      start    = 1'b0;
      wait_len = (!rs_q && dat_q == 8'h01) ? TW'(T_CLR_CYC) : TW'(T_CMD_CYC);
      case (state_q)
         S_PWRUP: begin
            if (tmr_q == TW'(T_PWRUP_CYC - 1)) begin
               state_d = S_INIT;
               idx_d   = 4'd0;
               start   = 1'b1;
            end
         end
         S_FRAME: begin
            state_d  = S_ADDR1;
            snap_a_d = a;
            snap_b_d = b;
            start    = 1'b1;
         end
         default: begin
            case (phase_q)
               P_SETUP: if (tmr_q == TW'(T_E_CYC - 1)) begin
                  phase_d = P_PULSE;
                  tmr_d   = '0;
                  e_d     = 1'b1;
               end
               P_PULSE: if (tmr_q == TW'(T_E_CYC - 1)) begin
                  phase_d = P_WAIT;
                  tmr_d   = '0;
                  e_d     = 1'b0;
               end
               default: if (tmr_q == wait_len - TW'(1)) begin
                  start = 1'b1;
                  case (state_q)
                     S_INIT: begin
                        if (idx_q == 4'd5) begin
                           state_d  = S_ADDR1;
                           idx_d    = 4'd0;
                           init_d   = 1'b1;
                           snap_a_d = a;
                           snap_b_d = b;
                        end else begin
                           idx_d = idx_q + 4'd1;
                        end
                     end
                     S_ADDR1: state_d = S_LINE1;
                     S_ADDR2: state_d = S_LINE2;
                     S_LINE1: begin
                        idx_d = idx_q + 4'd1;   // 15 -> 0 lands exactly on the line change
                        if (idx_q == 4'd15) state_d = S_ADDR2;
                     end
                     default: begin
                        idx_d = idx_q + 4'd1;
                        if (idx_q == 4'd15) begin
                           state_d = S_FRAME;
                           fdone_d = 1'b1;
                           start   = 1'b0;
                        end
                     end
                  endcase
               end
            endcase
         end
      endcase
      if (start) begin
         phase_d       = P_SETUP;
         tmr_d         = '0;
         {rs_d, dat_d} = byte_for(state_d, idx_d, snap_a_d, snap_b_d);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_PWRUP;
         phase_q  <= P_SETUP;
         tmr_q    <= '0;
         idx_q    <= '0;
         e_q      <= 1'b0;
         rs_q     <= 1'b0;
         dat_q    <= 8'h00;
         init_q   <= 1'b0;
         fdone_q  <= 1'b0;
         snap_a_q <= '0;
         snap_b_q <= '0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         tmr_q    <= tmr_d;
         idx_q    <= idx_d;
         e_q      <= e_d;
         rs_q     <= rs_d;
         dat_q    <= dat_d;
         init_q   <= init_d;
         fdone_q  <= fdone_d;
         snap_a_q <= snap_a_d;
         snap_b_q <= snap_b_d;
      end
   end

   assign lcd_e      = e_q;
   assign lcd_rs     = rs_q;
   assign lcd_d      = dat_q;
   assign init_done  = init_q;
   assign frame_done = fdone_q;
endmodule

// File: tb/tb_lcd_hd44780_hex.sv
// Bench for lcd_hd44780_hex: per-cycle comparison against a transfer-level model
// of the LCD bus, plus literal pins on init bytes, frame contents and timing.
module tb_lcd_hd44780_hex;
   localparam int TP = 10, TE = 2, TC = 4, TL = 8;

   logic        clk = 1'b0, rst = 1'b1;
   logic [63:0] a = '0, b = '0;
   logic        lcd_rs, lcd_e, init_done, frame_done;
   logic [7:0]  lcd_d;

   lcd_hd44780_hex #(.T_PWRUP_CYC(TP), .T_E_CYC(TE), .T_CMD_CYC(TC), .T_CLR_CYC(TL)) dut (
      .clk(clk), .reset(rst), .a(a), .b(b), .lcd_rs(lcd_rs), .lcd_e(lcd_e),
      .lcd_d(lcd_d), .init_done(init_done), .frame_done(frame_done));

   always #5 clk = ~clk;

   typedef struct packed {logic e; logic rs; logic [7:0] d; logic idn; logic fd;} exp_t;

   exp_t        q[$];
   logic [8:0]  seen[$], fb[$];
   int          checks = 0, errors = 0;
   int          cyc = 0, rel_cyc = 0, last_fd = -1, epoch = 0, epoch_frames = 0, xfer_in_frame = 0;
   bit          need_init = 1'b1, idn_seen = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [7:0] hexc(input logic [3:0] n);
      return (n < 10) ? 8'(48 + n) : 8'(55 + n);
   endfunction

   // One byte transfer as seen on the bus: setup, E high, then the settle wait
   task automatic push_xfer(input logic rs, input logic [7:0] d, input logic idn);
      int w;
      w = (!rs && d == 8'h01) ? TL : TC;
      repeat (TE) q.push_back({1'b0, rs, d, idn, 1'b0});
      repeat (TE) q.push_back({1'b1, rs, d, idn, 1'b0});
      repeat (w)  q.push_back({1'b0, rs, d, idn, 1'b0});
   endtask

   task automatic gen_init();
      logic [7:0] cmds[6];
      cmds = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
      // outputs idle for the edges before the power-up wait expires
      repeat (TP - 1) q.push_back('0);
      for (int i = 0; i < 6; i++) push_xfer(1'b0, cmds[i], 1'b0);
   endtask

   task automatic gen_frame(input logic [63:0] sa, input logic [63:0] sb);
      push_xfer(1'b0, 8'h80, 1'b1);
      for (int i = 15; i >= 0; i--) push_xfer(1'b1, hexc(sa[i*4 +: 4]), 1'b1);
      push_xfer(1'b0, 8'hC0, 1'b1);
      for (int i = 15; i >= 0; i--) push_xfer(1'b1, hexc(sb[i*4 +: 4]), 1'b1);
      q.push_back({1'b0, 1'b1, hexc(sb[3:0]), 1'b1, 1'b1});
   endtask

   task automatic chk_frame(input string s1, input string s2);
      logic [8:0] ex[$];
      ex.push_back(9'h080);
      for (int i = 0; i < 16; i++) ex.push_back({1'b1, s1[i]});
      ex.push_back(9'h0C0);
      for (int i = 0; i < 16; i++) ex.push_back({1'b1, s2[i]});
      chk("frame_len", fb.size(), 34);
      for (int i = 0; i < 34 && i < fb.size(); i++) chk("frame_byte", {23'd0, fb[i]}, {23'd0, ex[i]});
   endtask

   initial begin : monitor
      exp_t ex, ac;
      logic pe, prs;
      logic [7:0] pd;
      logic [8:0] init_lit[6];
      init_lit = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h006, 9'h001};
      pe = 1'b0; prs = 1'b0; pd = 8'h00;
      forever begin
         @(posedge clk); #1;
         cyc++;
         ac = {lcd_e, lcd_rs, lcd_d, init_done, frame_done};
         if (rst) begin
            ex = '0;
            q.delete(); seen.delete(); fb.delete();
            need_init = 1'b1; idn_seen = 1'b0; last_fd = -1; epoch_frames = 0; xfer_in_frame = 0;
            pe = 1'b0;
            chk("reset_outputs", {20'd0, ac}, {20'd0, ex});
         end else begin
            if (need_init) begin
               gen_init(); need_init = 1'b0; rel_cyc = cyc; epoch++;
            end
            if (q.size() == 0) gen_frame(a, b);
            ex = q.pop_front();
            chk("bus_cycle", {20'd0, ac}, {20'd0, ex});
            if (pe) chk("held_while_e", {23'd0, lcd_rs, lcd_d}, {23'd0, prs, pd});
            if (lcd_e && !pe) begin
               if (init_done) begin fb.push_back({lcd_rs, lcd_d}); xfer_in_frame++; end
               else seen.push_back({lcd_rs, lcd_d});
            end
            if (init_done && !idn_seen) begin
               idn_seen = 1'b1;
               chk("init_done_latency", cyc - rel_cyc + 1, 62);
               chk("init_count", seen.size(), 6);
               for (int i = 0; i < 6 && i < seen.size(); i++) chk("init_byte", {23'd0, seen[i]}, {23'd0, init_lit[i]});
            end
            if (frame_done) begin
               epoch_frames++;
               if (last_fd >= 0) chk("frame_interval", cyc - last_fd, 273);
               last_fd = cyc;
               if (epoch == 1 && epoch_frames <= 2) chk_frame("0123456789ABCDEF", "FEDCBA9876543210");
               if (epoch == 1 && epoch_frames == 3) chk_frame("FFFFFFFFFFFFFFFF", "FEDCBA9876543210");
               if (epoch == 2 && epoch_frames == 1) chk_frame("00000000DEADBEEF", "0F1E2D3C4B5A6978");
               fb.delete();
               xfer_in_frame = 0;
            end
         end
         pe = lcd_e; prs = lcd_rs; pd = lcd_d;
      end
   end

   task automatic wait_frames(input int n, input string nm);
      for (int i = 0; i < n * 300 + 200 && epoch_frames < n; i++) @(negedge clk);
      chk(nm, (epoch_frames >= n) ? 1 : 0, 1);
   endtask

   initial begin : stim
      a = 64'h0123_4567_89AB_CDEF;
      b = 64'hFEDC_BA98_7654_3210;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_frames(1, "wait_frame1");
      // change a mid-line-1 of frame 2; only frame 3 may show it
      for (int i = 0; i < 300 && xfer_in_frame < 6; i++) @(negedge clk);
      chk("reach_char5", (xfer_in_frame >= 6) ? 1 : 0, 1);
      a = '1;
      wait_frames(3, "wait_frame3");
      repeat (1500) begin
         @(negedge clk);
         if ($urandom_range(0, 79) == 0) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
         end
      end
      // asynchronous reset in the middle of an E pulse on line 2
      for (int i = 0; i < 400 && !(xfer_in_frame >= 20 && lcd_e); i++) @(posedge clk);
      chk("reach_line2_pulse", (xfer_in_frame >= 20 && lcd_e) ? 1 : 0, 1);
      #3 rst = 1'b1;
      #1 chk("e_async_drop", {31'd0, lcd_e}, 0);
      chk("init_done_in_reset", {31'd0, init_done}, 0);
      @(negedge clk);
      a = 64'h0000_0000_DEAD_BEEF;
      b = 64'h0F1E_2D3C_4B5A_6978;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_frames(2, "wait_epoch2_frames");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/lcd_hd44780_hex.md
LCD_HD44780_HEX -- requirements
Module: lcd_hd44780_hex

Interface
REQ-001 Parameter T_PWRUP_CYC, default 1_000_000, power-on wait in clk cycles (20 ms at 50 MHz).
REQ-002 Parameter T_E_CYC, default 25, length in cycles of each of the setup phase and the E-high phase.
REQ-003 Parameter T_CMD_CYC, default 2_500, post-E wait in cycles for normal commands and characters (50 us).
REQ-004 Parameter T_CLR_CYC, default 100_000, post-E wait in cycles after the clear command (2 ms).
REQ-005 clk  input  1  system clock; one clock only, all state on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 a  input  64  value shown as 16 hex digits on line 1.
REQ-008 b  input  64  value shown as 16 hex digits on line 2.
REQ-009 lcd_rs  output  1  register select: 0 = command, 1 = data.
REQ-010 lcd_e  output  1  HD44780 enable strobe.
REQ-011 lcd_d  output  8  HD44780 data bus, 8-bit mode, write-only.
REQ-012 init_done  output  1  level; high once the init sequence has completed.
REQ-013 frame_done  output  1  one-cycle pulse after the last character of line 2 is written.

Function
REQ-014 Every byte transfer SHALL have three phases: SETUP, PULSE, WAIT.
REQ-015 SETUP: lcd_rs and lcd_d valid, lcd_e=0, for T_E_CYC cycles.
REQ-016 PULSE: lcd_e=1 for T_E_CYC cycles, with lcd_rs and lcd_d unchanged.
REQ-017 WAIT: lcd_e=0 for T_CLR_CYC cycles after command 0x01 and T_CMD_CYC cycles after any other byte, with lcd_rs and lcd_d held.
REQ-018 lcd_rs and lcd_d SHALL change only at the first cycle of a SETUP phase.
REQ-019 States: PWRUP, INIT, ADDR1, LINE1, ADDR2, LINE2, FRAME.
REQ-020 PWRUP: wait T_PWRUP_CYC cycles with all outputs at reset values, then go to INIT.
REQ-021 INIT: send commands 0x38, 0x38, 0x38, 0x0C, 0x06, 0x01 in order, with rs=0.
REQ-022 init_done SHALL rise in the first cycle after the WAIT of 0x01 ends and stay high until reset.
REQ-023 ADDR1: on entry, capture a and b into snapshot registers, then send command 0x80.
REQ-024 LINE1: send 16 data bytes (rs=1) for the snapshot of a, nibble [63:60] first, [3:0] last.
REQ-025 ADDR2: send command 0xC0.
REQ-026 LINE2: send 16 data bytes (rs=1) for the snapshot of b, in the same nibble order.
REQ-027 FRAME: assert frame_done for exactly one cycle, then return to ADDR1; refresh is continuous.
REQ-028 Hex encoding: nibble 0-9 maps to 0x30-0x39; nibble A-F maps to 0x41-0x46 (uppercase).
REQ-029 Changes on a/b during a frame SHALL NOT affect that frame; both lines come from one snapshot taken at the same edge.
REQ-030 The character index is 4 bits and wraps 15 -> 0 at the line change; no other wrap is permitted.
REQ-031 Timer counters SHALL be sized for the largest parameter, using $clog2 of the maximum plus 1.
REQ-032 Frame length is 34 transfers, each lasting 2*T_E_CYC+T_CMD_CYC cycles, plus 1 cycle for FRAME.

Reset
REQ-033 While reset is high, outputs SHALL be: lcd_e=0, lcd_rs=0, lcd_d=8'h00, init_done=0, frame_done=0.
REQ-034 While reset is high, the state SHALL be PWRUP with all counters and snapshots cleared.
REQ-035 Reset asserted mid-transfer SHALL drop lcd_e asynchronously in the same instant.
REQ-036 After reset release, the full PWRUP and INIT sequence SHALL repeat; no partial byte is ever completed.

Verification (T_PWRUP_CYC=10, T_E_CYC=2, T_CMD_CYC=4, T_CLR_CYC=8)
REQ-037 Release reset -> lcd_e stays 0 for 10 cycles, then six E pulses each 2 cycles high carrying 0x38,0x38,0x38,0x0C,0x06,0x01 with rs=0; the gap after 0x01 is 8 cycles, then init_done=1.
REQ-038 a=64'h0123_4567_89AB_CDEF, b=64'hFEDC_BA98_7654_3210 -> bytes 0x80, then "0123456789ABCDEF" in ASCII, then 0xC0, then "FEDCBA9876543210", then a one-cycle frame_done pulse.
REQ-039 Change a to all-ones at the 5th character of line 1 -> this frame still shows the old a; the next frame shows "FFFFFFFFFFFFFFFF".
REQ-040 Measure the interval between consecutive frame_done pulses -> exactly 34*(2+2+4)+1 = 273 cycles.
REQ-041 Assert reset asynchronously during a PULSE phase of line 2 -> lcd_e drops before the next clk edge; after release, init_done=0 and the PWRUP wait restarts at 10 cycles.
REQ-042 Monitor the full run -> lcd_d and lcd_rs never change while lcd_e=1, or in the cycle lcd_e falls.
